// File: rtl/t05_htree_mem_ctrl_if.sv
// Bundle between the Huffman-tree memory controller and its environment:
// the tree-builder write port, the codebook-walker read port and the
// 32-bit SRAM port.
//   master : requesters + SRAM side (drives requests, sram_rdata, sram_busy)
//   slave  : the controller (drives pulses, rd_node, busy, SRAM strobes)
interface t05_htree_mem_ctrl_if;
    logic        rd_req;
    logic [6:0]  rd_index;
    logic        rd_valid;
    logic [70:0] rd_node;
    logic        wr_req;
    logic [6:0]  wr_index;
    logic [70:0] wr_node;
    logic        wr_done;
    logic        busy;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_read;
    logic        sram_write;
    logic        sram_busy;

    modport master (
        output rd_req, rd_index, wr_req, wr_index, wr_node, sram_rdata, sram_busy,
        input  rd_valid, rd_node, wr_done, busy, sram_addr, sram_wdata, sram_read, sram_write
    );

    modport slave (
        input  rd_req, rd_index, wr_req, wr_index, wr_node, sram_rdata, sram_busy,
        output rd_valid, rd_node, wr_done, busy, sram_addr, sram_wdata, sram_read, sram_write
    );
endinterface

// File: rtl/t05_htree_mem_ctrl.sv
// SRAM sequencer/arbiter for the 71-bit Huffman tree node array.
// A node {max_index[6:0], left[8:0], right[8:0], sum[45:0]} occupies three
// 32-bit words at BASE_ADDR + index*NODE_BYTES + 4k:
//   w0 = node[31:0], w1 = node[63:32], w2 = {25'b0, node[70:64]}.
// Ports:
//   clk, nrst : clock, synchronous active-low reset
//   bus       : slave side of t05_htree_mem_ctrl_if (read port, write port,
//               busy, SRAM port). A word completes on a cycle with its strobe
//               high and sram_busy low.
// A one-node read cache returns a repeated read of the same index one cycle
// after the request is sampled, without touching the SRAM.
module t05_htree_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned NODE_BYTES = 12
) (
    input logic                  clk,
    input logic                  nrst,
    t05_htree_mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state;
    logic        op_write;
    logic [1:0]  word_cnt;
    logic [6:0]  idx;
    logic [70:0] node_buf;      // write data, or read assembly for w0/w1
    logic        cache_valid;
    logic [6:0]  cache_index;
    logic [70:0] cache_node;
    logic        last_grant_wr; // 1: the last contended grant went to write
    logic        grant_wr;
    logic        rd_hit;

    function automatic logic [31:0] word_addr(input logic [6:0] index, input logic [1:0] k);
        return BASE_ADDR + 32'(index) * NODE_BYTES + 32'(k) * 32'd4;
    endfunction

    function automatic logic [31:0] word_data(input logic [70:0] node, input logic [1:0] k);
        logic [31:0] w;
        unique case (k)
            2'd0:    w = node[31:0];
            2'd1:    w = node[63:32];
            default: w = {25'b0, node[70:64]};
        endcase
        return w;
    endfunction

    // Round-robin only matters under contention: the side that did not win
    // the previous contention gets the port.
    always_comb begin
        grant_wr = bus.wr_req && (!bus.rd_req || !last_grant_wr);
        rd_hit   = cache_valid && (cache_index == bus.rd_index);
        bus.busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state          <= IDLE;
            op_write       <= 1'b0;
            word_cnt       <= '0;
            idx            <= '0;
            node_buf       <= '0;
            cache_valid    <= 1'b0;
            cache_index    <= '0;
            cache_node     <= '0;
            last_grant_wr  <= 1'b1;
            bus.rd_valid   <= 1'b0;
            bus.rd_node    <= '0;
            bus.wr_done    <= 1'b0;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.sram_read  <= 1'b0;
            bus.sram_write <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.rd_req || bus.wr_req) begin
                        if (bus.rd_req && bus.wr_req) begin
                            last_grant_wr <= grant_wr;
                        end
                        word_cnt <= '0;
                        if (grant_wr) begin
                            op_write       <= 1'b1;
                            idx            <= bus.wr_index;
                            node_buf       <= bus.wr_node;
                            bus.sram_addr  <= word_addr(bus.wr_index, 2'd0);
                            bus.sram_wdata <= word_data(bus.wr_node, 2'd0);
                            bus.sram_write <= 1'b1;
                            state          <= XFER;
                        end else if (rd_hit) begin
                            op_write     <= 1'b0;
                            bus.rd_node  <= cache_node;
                            bus.rd_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            op_write      <= 1'b0;
                            idx           <= bus.rd_index;
                            bus.sram_addr <= word_addr(bus.rd_index, 2'd0);
                            bus.sram_read <= 1'b1;
                            state         <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (!bus.sram_busy) begin
                        if (word_cnt == 2'd2) begin
                            bus.sram_read  <= 1'b0;
                            bus.sram_write <= 1'b0;
                            state          <= DONE;
                            if (op_write) begin
                                bus.wr_done <= 1'b1;
                                if (idx == cache_index) begin
                                    cache_node <= node_buf;
                                end
                            end else begin
                                // Last word goes straight to rd_node and the cache;
                                // only its low 7 bits carry node data.
                                bus.rd_valid <= 1'b1;
                                bus.rd_node  <= {bus.sram_rdata[6:0], node_buf[63:0]};
                                cache_node   <= {bus.sram_rdata[6:0], node_buf[63:0]};
                                cache_index  <= idx;
                                cache_valid  <= 1'b1;
                            end
                        end else begin
                            if (!op_write) begin
                                if (word_cnt == 2'd0) node_buf[31:0]  <= bus.sram_rdata;
                                else                  node_buf[63:32] <= bus.sram_rdata;
                            end
                            word_cnt       <= word_cnt + 2'd1;
                            bus.sram_addr  <= word_addr(idx, word_cnt + 2'd1);
                            bus.sram_wdata <= word_data(node_buf, word_cnt + 2'd1);
                        end
                    end
                end
                DONE: begin
                    bus.rd_valid <= 1'b0;
                    bus.wr_done  <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t05_htree_mem_ctrl.sv
module tb_t05_htree_mem_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [70:0] NODE3 = {7'd8, 9'h100, 9'h041, 46'd10};
    localparam logic [70:0] NEW5  = {7'd127, 9'h1FF, 9'h000, 46'h2AAA_AAAA_AAAA};

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    t05_htree_mem_ctrl_if bus ();

    t05_htree_mem_ctrl #(.BASE_ADDR(BASE), .NODE_BYTES(12)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // SRAM contents (word-indexed) and the reference node array.
    logic [31:0] sram_mem [0:383];
    logic [70:0] ref_node [0:127];

    always_comb begin
        if (bus.sram_addr[31:2] < 30'd384) bus.sram_rdata = sram_mem[bus.sram_addr[10:2]];
        else                               bus.sram_rdata = 32'hDEAD_BEEF;
    end

    // Reference model state: a transaction is idle / transferring / pulsing.
    int          m_phase   = 0;
    bit          m_wr      = 1'b0;
    logic [6:0]  m_idx     = '0;
    logic [70:0] m_node    = '0;
    int          m_words   = 0;
    bit          m_last_wr = 1'b1;
    bit          m_cv      = 1'b0;
    logic [6:0]  m_ci      = '0;
    logic [70:0] m_rd_node = '0;
    int          stall_cnt = 0;
    int          busy_mode = 0;   // 0 zero-wait, 1 random, 2 two stalls on read word 1

    function automatic logic [31:0] wmap(input logic [70:0] node, input int k);
        if (k == 0) return node[31:0];
        if (k == 1) return node[63:32];
        return {25'b0, node[70:64]};
    endfunction

    function automatic logic [70:0] rand71();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[70:0];
    endfunction

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare at the negedge, then advance the model to the next edge.
    task automatic step_model();
        logic       sb;
        logic [31:0] ea;
        bit r, w, pw;
        sb = 1'b0;
        if (m_phase == 1) begin
            if (busy_mode == 1) sb = ($urandom_range(0, 3) == 0);
            else if (busy_mode == 2 && !m_wr && m_words == 1 && stall_cnt < 2) begin
                sb = 1'b1;
                stall_cnt++;
            end
        end
        bus.sram_busy = sb;

        chk("sram_read",  71'(bus.sram_read),  71'(m_phase == 1 && !m_wr));
        chk("sram_write", 71'(bus.sram_write), 71'(m_phase == 1 && m_wr));
        chk("rd_valid",   71'(bus.rd_valid),   71'(m_phase == 2 && !m_wr));
        chk("wr_done",    71'(bus.wr_done),    71'(m_phase == 2 && m_wr));
        chk("busy",       71'(bus.busy),       71'(m_phase != 0));
        chk("rd_node",    bus.rd_node,         m_rd_node);
        if (m_phase == 1) begin
            ea = BASE + 32'(m_idx) * 32'd12 + 32'(m_words) * 32'd4;
            chk("sram_addr", 71'(bus.sram_addr), 71'(ea));
            if (m_wr) chk("sram_wdata", 71'(bus.sram_wdata), 71'(wmap(m_node, m_words)));
        end
        if (bus.sram_write === 1'b1 && !sb && bus.sram_addr[31:2] < 30'd384)
            sram_mem[bus.sram_addr[10:2]] = bus.sram_wdata;

        if (nrst === 1'b0) begin
            m_phase = 0; m_cv = 1'b0; m_last_wr = 1'b1; m_rd_node = '0;
        end else begin
            case (m_phase)
                0: begin
                    r = bus.rd_req; w = bus.wr_req;
                    if (r || w) begin
                        pw = (r && w) ? !m_last_wr : w;
                        if (r && w) m_last_wr = pw;
                        m_wr = pw;
                        m_idx = pw ? bus.wr_index : bus.rd_index;
                        m_node = bus.wr_node;
                        m_words = 0;
                        stall_cnt = 0;
                        if (!pw && m_cv && m_ci == m_idx) begin
                            m_phase = 2;
                            m_rd_node = ref_node[m_idx];
                        end else m_phase = 1;
                    end
                end
                1: if (!sb) begin
                    m_words++;
                    if (m_words == 3) begin
                        m_phase = 2;
                        if (m_wr) ref_node[m_idx] = m_node;
                        else begin
                            m_rd_node = ref_node[m_idx];
                            m_cv = 1'b1;
                            m_ci = m_idx;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
    endtask

    // Issue a read and/or write in the current (idle) cycle c0; latencies are
    // the cycle numbers (c1 = 1) of the pulses.
    task automatic do_txn(input bit do_rd, input bit do_wr, input logic [6:0] ri,
                          input logic [6:0] wi, input logic [70:0] wn,
                          output int rd_lat, output int wr_lat, output int rd_strobes);
        int  n;
        bit  single;
        single = !(do_rd && do_wr);
        bus.rd_req = do_rd; bus.rd_index = ri;
        bus.wr_req = do_wr; bus.wr_index = wi; bus.wr_node = wn;
        rd_lat = -1; wr_lat = -1; rd_strobes = 0; n = 0;
        while ((bus.rd_req || bus.wr_req) && n < 100) begin
            tick();
            n++;
            if (bus.sram_read) rd_strobes++;
            if (bus.rd_req && bus.rd_valid) begin
                rd_lat = n; bus.rd_req = 1'b0; bus.rd_index = 7'($urandom());
            end
            if (bus.wr_req && bus.wr_done) begin
                wr_lat = n; bus.wr_req = 1'b0; bus.wr_index = 7'($urandom()); bus.wr_node = rand71();
            end
            if (n == 1 && single) begin
                // Inputs after the grant edge must not affect the transaction.
                if (bus.rd_req) bus.rd_index = 7'($urandom());
                if (bus.wr_req) begin bus.wr_index = 7'($urandom()); bus.wr_node = rand71(); end
            end
        end
        if (bus.rd_req || bus.wr_req) begin
            n_checks++; n_fails++;
            $display("FAIL timeout: no pulse within 100 cycles (rd_req=%0b wr_req=%0b)", bus.rd_req, bus.wr_req);
            bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        end
        tick();
    endtask

    initial begin
        int rl, wl, rs, sel;
        logic [6:0] ia, ib;
        nrst = 1'b0;
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        bus.rd_index = '0; bus.wr_index = '0; bus.wr_node = '0;
        bus.sram_busy = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ref_node[i] = rand71();
            sram_mem[i*3]   = wmap(ref_node[i], 0);
            sram_mem[i*3+1] = wmap(ref_node[i], 1);
            sram_mem[i*3+2] = {25'($urandom()), ref_node[i][70:64]};
        end

        tick(); tick();
        chk("reset rd_node",    bus.rd_node, '0);
        chk("reset sram_addr",  71'(bus.sram_addr), '0);
        chk("reset sram_wdata", 71'(bus.sram_wdata), '0);
        chk("reset busy",       71'(bus.busy), '0);
        nrst = 1'b1;
        tick();

        // Write node 3, zero-wait.
        do_txn(0, 1, 7'd0, 7'd3, NODE3, rl, wl, rs);
        chk("wr3 latency", 71'(wl), 71'(4));
        chk("wr3 w0 @0x24", 71'(sram_mem[9]),  71'(32'h0000_000A));
        chk("wr3 w1 @0x28", 71'(sram_mem[10]), 71'(32'h8010_4000));
        chk("wr3 w2 @0x2C", 71'(sram_mem[11]), 71'(32'h0000_0008));

        // Read node 3 (miss), then re-read (hit).
        do_txn(1, 0, 7'd3, 7'd0, '0, rl, wl, rs);
        chk("rd3 miss latency", 71'(rl), 71'(4));
        chk("rd3 miss data", bus.rd_node, NODE3);
        do_txn(1, 0, 7'd3, 7'd0, '0, rl, wl, rs);
        chk("rd3 hit latency", 71'(rl), 71'(1));
        chk("rd3 hit sram_read cycles", 71'(rs), 71'(0));
        chk("rd3 hit data", bus.rd_node, NODE3);

        // Contention after reset: read first, then write; next contention flips.
        do_reset();
        do_txn(1, 1, 7'd10, 7'd20, rand71(), rl, wl, rs);
        chk("contend1 rd latency", 71'(rl), 71'(4));
        chk("contend1 wr latency", 71'(wl), 71'(9));
        do_txn(1, 1, 7'd11, 7'd21, rand71(), rl, wl, rs);
        chk("contend2 wr latency", 71'(wl), 71'(4));
        chk("contend2 rd latency", 71'(rl), 71'(9));

        // Two stall cycles on read word 1.
        busy_mode = 2;
        do_txn(1, 0, 7'd40, 7'd0, '0, rl, wl, rs);
        chk("stall rd latency", 71'(rl), 71'(6));
        busy_mode = 0;

        // Cache coherence on node 5.
        do_txn(1, 0, 7'd5, 7'd0, '0, rl, wl, rs);
        chk("rd5 miss latency", 71'(rl), 71'(4));
        do_txn(0, 1, 7'd0, 7'd5, NEW5, rl, wl, rs);
        do_txn(1, 0, 7'd5, 7'd0, '0, rl, wl, rs);
        chk("rd5 hit after write latency", 71'(rl), 71'(1));
        chk("rd5 hit after write data", bus.rd_node, NEW5);
        do_txn(0, 1, 7'd0, 7'd6, rand71(), rl, wl, rs);
        do_txn(1, 0, 7'd5, 7'd0, '0, rl, wl, rs);
        chk("rd5 hit after wr6 latency", 71'(rl), 71'(1));
        chk("rd5 hit after wr6 data", bus.rd_node, NEW5);

        // Reset during word 1 of a write (same data, so SRAM stays coherent).
        bus.wr_req = 1'b1; bus.wr_index = 7'd5; bus.wr_node = ref_node[5];
        tick(); tick();
        nrst = 1'b0;
        tick();
        chk("abort busy",       71'(bus.busy), '0);
        chk("abort sram_write", 71'(bus.sram_write), '0);
        chk("abort sram_read",  71'(bus.sram_read), '0);
        chk("abort wr_done",    71'(bus.wr_done), '0);
        bus.wr_req = 1'b0; nrst = 1'b1;
        tick();
        chk("abort no late wr_done", 71'(bus.wr_done), '0);
        do_txn(1, 0, 7'd5, 7'd0, '0, rl, wl, rs);
        chk("rd5 after reset latency", 71'(rl), 71'(4));
        chk("rd5 after reset data", bus.rd_node, NEW5);

        // Randomized traffic with random SRAM stalls, including index 127.
        busy_mode = 1;
        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 9);
            ia = (sel == 9) ? 7'd127 : 7'(sel);
            sel = $urandom_range(0, 9);
            ib = (sel == 9) ? 7'd127 : 7'(sel);
            sel = $urandom_range(0, 2);
            do_txn(sel != 1, sel != 0, ia, ib, rand71(), rl, wl, rs);
        end
        busy_mode = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
